// File: rtl/limb_pkg.sv
// Shared types for the fetch path: word width, word type, reset fetch address
// and the {pc, inst} entry carried through the prefetch queue.
// Ports: none (package).
package limb_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_PC = 32'h0;

  typedef struct packed {
    word_t pc;
    word_t inst;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_queue.sv
// Purpose: synchronous FIFO of fetch_entry_t feeding the fetch unit's output.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: none internally; the caller must never push when full.
// Ports: clk, rst_n (async active-low); push/push_entry write; pop retires
//        head; flush empties the queue and wins over a same-cycle push;
//        count = occupancy; head = oldest entry (stale when count = 0).
module prefetch_queue
  import limb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t      storage [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  assign head = storage[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Data array needs no reset: count gates whether head is meaningful.
  always_ff @(posedge clk) begin
    if (push && !flush) storage[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Purpose: holds the PC, issues one RAM read per cycle, queues fetched words.
// Latency: issue -> valid is 2 cycles (1 with IFU_BYPASS_EN defined).
// Backpressure: fetch stops once queued + in-flight words reach DEPTH.
// Ports: clk, rst_n (async active-low); mem_a/mem_rw/mem_dout to the RAM;
//        redirect/redirect_pc restart fetch; inst_valid/inst_ready/inst/
//        inst_pc handshake to the control unit.
// Config macro: IFU_BYPASS_EN forwards an arriving word straight to the
//        outputs when the queue is empty.
module instruction_fetch_unit
  import limb_pkg::*;
#(
  parameter int    DEPTH    = 2,
  parameter word_t RESET_PC = limb_pkg::RESET_PC,
  localparam int   CW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [WORD_W-1:0] mem_a,
  output logic              mem_rw,
  input  logic [WORD_W-1:0] mem_dout,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [WORD_W-1:0] inst,
  output logic [WORD_W-1:0] inst_pc
);

  logic [WORD_W-1:0] fetch_pc;
  logic [WORD_W-1:0] inflight_pc;
  logic              inflight;

  logic [CW-1:0]     q_count;
  fetch_entry_t      q_head;
  fetch_entry_t      q_in;
  logic              q_push;
  logic              q_pop;
  logic              q_nonempty;

  logic              pop;
  logic              issue;
  logic [CW:0]       occupancy;

  assign mem_a      = fetch_pc;
  assign mem_rw     = 1'b0;
  assign q_nonempty = (q_count != '0);
  assign q_in       = '{pc: inflight_pc, inst: mem_dout};

`ifdef IFU_BYPASS_EN
  logic bypass;

  // An arriving word is shown directly only when nothing older is queued.
  assign bypass     = !q_nonempty && inflight;
  assign inst_valid = q_nonempty || bypass;
  assign inst       = q_nonempty ? q_head.inst : (bypass ? mem_dout    : '0);
  assign inst_pc    = q_nonempty ? q_head.pc   : (bypass ? inflight_pc : '0);
  assign q_push     = inflight && !(bypass && inst_ready);
  assign q_pop      = pop && q_nonempty;
`else
  assign inst_valid = q_nonempty;
  assign inst       = q_nonempty ? q_head.inst : '0;
  assign inst_pc    = q_nonempty ? q_head.pc   : '0;
  assign q_push     = inflight;
  assign q_pop      = pop;
`endif

  assign pop = inst_valid && inst_ready;

  // A pop implies a queued or arriving word, so this never underflows.
  assign occupancy = {1'b0, q_count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
  assign issue     = !redirect && (occupancy < (CW + 1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      // Dropping inflight discards the word returning next cycle.
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else if (issue) begin
      fetch_pc    <= fetch_pc + 32'd1;
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  prefetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (q_push),
    .push_entry (q_in),
    .pop        (q_pop),
    .flush      (redirect),
    .count      (q_count),
    .head       (q_head)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef IFU_BYPASS_EN
  localparam int FIRST = 1;   // cycle of first inst_valid after reset release
  localparam int REDIR = 2;   // redirect-to-valid latency
`else
  localparam int FIRST = 2;
  localparam int REDIR = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_a;
  logic        mem_rw;
  logic [31:0] mem_dout = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int checks = 0;
  int failures = 0;

  // Scoreboard: the consumer must see a gapless word-address stream.
  logic [31:0] exp_pc;
  int          pops;
  logic        popped_now;
  logic [31:0] last_pop_pc;
  logic        prev_hold;
  logic [31:0] prev_inst;
  logic [31:0] prev_pc;

  logic [31:0] boot [4];

  instruction_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_a       (mem_a),
    .mem_rw      (mem_rw),
    .mem_dout    (mem_dout),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'hE3A01005;
      32'd1:   return 32'hE3A02007;
      32'd2:   return 32'hE3A03009;
      32'd3:   return 32'hE3A0400B;
      default: return {a[15:0], a[31:16]} ^ 32'h5A5AC3C3;
    endcase
  endfunction

  // RAM samples the address at the edge; data is valid the following cycle.
  always @(posedge clk) mem_dout <= ram_word(mem_a);

  // One cycle: drive inputs for the coming edge, then observe and score.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    inst_ready  = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
    popped_now = 1'b0;
    if (prev_hold) begin
      checks++;
      if (!inst_valid || inst !== prev_inst || inst_pc !== prev_pc) begin
        failures++;
        $display("FAIL stall_hold: got v=%0b pc=%h inst=%h, need v=1 pc=%h inst=%h",
                 inst_valid, inst_pc, inst, prev_pc, prev_inst);
      end
    end
    if (!inst_valid) begin
      checks++;
      if (inst !== 32'h0 || inst_pc !== 32'h0) begin
        failures++;
        $display("FAIL idle_zero: got pc=%h inst=%h, need 0/0", inst_pc, inst);
      end
    end else if (inst_ready) begin
      checks++;
      if (inst_pc !== exp_pc || inst !== ram_word(exp_pc)) begin
        failures++;
        $display("FAIL stream: got pc=%h inst=%h, need pc=%h inst=%h",
                 inst_pc, inst, exp_pc, ram_word(exp_pc));
      end
      popped_now  = 1'b1;
      last_pop_pc = inst_pc;
      exp_pc      = exp_pc + 32'd1;
      pops++;
    end
    prev_hold = inst_valid && !inst_ready && !redir;
    prev_inst = inst;
    prev_pc   = inst_pc;
    if (redir) exp_pc = rpc;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 ||
        mem_rw !== 1'b0 || mem_a !== RESET_PC) begin
      failures++;
      $display("FAIL %s: got v=%0b inst=%h pc=%h rw=%0b a=%h, need 0/0/0/0/%h",
               name, inst_valid, inst, inst_pc, mem_rw, mem_a, RESET_PC);
    end
  endtask

  // Leaves the bench at cycle 0: rst_n just released, first edge still ahead.
  task automatic do_reset(input logic rdy);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = rdy;
    #1;
    check_reset_outputs("reset_state");
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    exp_pc    = RESET_PC;
    prev_hold = 1'b0;
    #1;
    check_reset_outputs("release_cycle0");
  endtask

  task automatic test_reset;
    do_reset(1'b1);
    for (int c = 1; c <= FIRST + 3; c++) begin
      step(1'b1, 1'b0, 32'h0);
      checks++;
      if (c < FIRST) begin
        if (inst_valid !== 1'b0) begin
          failures++;
          $display("FAIL first_latency: cycle %0d got v=%0b, need 0", c, inst_valid);
        end
      end else if (inst_valid !== 1'b1 || inst_pc !== 32'(c - FIRST) ||
                   inst !== boot[c - FIRST]) begin
        failures++;
        $display("FAIL boot_seq: cycle %0d got v=%0b pc=%h inst=%h, need 1 pc=%0d inst=%h",
                 c, inst_valid, inst_pc, inst, c - FIRST, boot[c - FIRST]);
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] a_prev;
    int          p0;
    do_reset(1'b1);
    for (int c = 1; c < FIRST; c++) step(1'b1, 1'b0, 32'h0);
    a_prev = mem_a;
    for (int c = 0; c < 5; c++) begin
      a_prev = mem_a;
      step(1'b0, 1'b0, 32'h0);
    end
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'hE3A01005 || mem_a !== RESET_PC + DEPTH ||
        mem_a !== a_prev) begin
      failures++;
      $display("FAIL stall_full: got v=%0b inst=%h a=%h prev_a=%h, need 1 inst=E3A01005 a=%h",
               inst_valid, inst, mem_a, a_prev, RESET_PC + DEPTH);
    end
    p0 = pops;
    for (int c = 0; c < 12; c++) step(1'b1, 1'b0, 32'h0);
    checks++;
    if (pops - p0 != 12 || exp_pc !== RESET_PC + 12) begin
      failures++;
      $display("FAIL stall_release: got pops=%0d next=%h, need 12 next=%h",
               pops - p0, exp_pc, RESET_PC + 12);
    end
  endtask

  task automatic test_redirect_full;
    int lat;
    do_reset(1'b1);
    for (int c = 1; c < FIRST; c++) step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);             // let the queue fill
    step(1'b0, 1'b1, 32'h100);
    lat = -1;
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      step(1'b1, 1'b0, 32'h0);
      if (inst_valid) begin
        lat = k;
        checks++;
        if (inst_pc !== 32'h100) begin
          failures++;
          $display("FAIL redirect_target: got pc=%h, need 00000100", inst_pc);
        end
      end
    end
    checks++;
    if (lat != REDIR) begin
      failures++;
      $display("FAIL redirect_latency: got %0d cycles, need %0d", lat, REDIR);
    end
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_redirect_pop;
    int guard;
    logic seen;
    do_reset(1'b1);
    guard = 0;
    while (!(popped_now && last_pop_pc == 32'd4) && guard < 20) begin
      step(1'b1, 1'b0, 32'h0);
      guard++;
    end
    step(1'b1, 1'b1, 32'hFFFFFFFE);
    checks++;
    if (!popped_now || last_pop_pc !== 32'd5) begin
      failures++;
      $display("FAIL redirect_pop: got popped=%0b pc=%h, need 1 pc=00000005",
               popped_now, last_pop_pc);
    end
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      step(1'b1, 1'b0, 32'h0);
      if (inst_valid) begin
        seen = 1'b1;
        checks++;
        if (inst_pc !== 32'hFFFFFFFE) begin
          failures++;
          $display("FAIL redirect_next: got pc=%h, need FFFFFFFE", inst_pc);
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL redirect_next_timeout: got no valid, need pc=FFFFFFFE");
    end
    // Crosses the 32-bit wrap; the scoreboard expects FFFFFFFF then 0, 1.
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_reset_midstream;
    int guard;
    do_reset(1'b1);
    guard = 0;
    while (mem_a !== 32'h20 && guard < 80) begin
      step(1'b1, 1'b0, 32'h0);
      guard++;
    end
    checks++;
    if (mem_a !== 32'h20) begin
      failures++;
      $display("FAIL midstream_reach: got a=%h, need 00000020", mem_a);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midstream_reset");
    do_reset(1'b1);
    for (int c = 1; c <= FIRST + 2; c++) step(1'b1, 1'b0, 32'h0);
    checks++;
    if (exp_pc !== RESET_PC + 3) begin
      failures++;
      $display("FAIL midstream_restart: got next=%h, need %h", exp_pc, RESET_PC + 3);
    end
  endtask

`ifdef IFU_BYPASS_EN
  task automatic test_bypass;
    do_reset(1'b1);
    step(1'b1, 1'b0, 32'h0);
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'hE3A01005) begin
      failures++;
      $display("FAIL bypass_first: got v=%0b inst=%h, need 1 inst=E3A01005", inst_valid, inst);
    end
    for (int c = 0; c < 16; c++) begin
      step(1'b1, 1'b0, 32'h0);
      checks++;
      if (dut.q_count !== '0) begin
        failures++;
        $display("FAIL bypass_count: got %0d, need 0", dut.q_count);
      end
    end
  endtask
`endif

  task automatic test_random;
    int   gap;
    logic rdy;
    logic redir;
    logic [31:0] rpc;
    do_reset(1'b1);
    gap = 0;
    for (int c = 0; c < 400; c++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 19) == 0);
      rpc   = ($urandom_range(0, 1) != 0) ? $urandom : 32'hFFFFFFFD;
      step(rdy, redir, rpc);
      if (redir || !rdy || inst_valid) gap = 0;
      else gap++;
      checks++;
      if (gap > 3) begin
        failures++;
        $display("FAIL liveness: got %0d idle ready cycles, need at most 3", gap);
        gap = 0;
      end
    end
  endtask

  initial begin
    boot[0] = 32'hE3A01005;
    boot[1] = 32'hE3A02007;
    boot[2] = 32'hE3A03009;
    boot[3] = 32'hE3A0400B;
    exp_pc      = RESET_PC;
    pops        = 0;
    popped_now  = 1'b0;
    last_pop_pc = 32'h0;
    prev_hold   = 1'b0;
    prev_inst   = 32'h0;
    prev_pc     = 32'h0;

    test_reset();
    test_stall();
    test_redirect_full();
    test_redirect_pop();
    test_reset_midstream();
`ifdef IFU_BYPASS_EN
    test_bypass();
`endif
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage placed between the word-addressed boot/program RAM and the control unit. It holds the program counter, issues one read per cycle to the RAM, and absorbs the RAM's one-cycle read latency. Fetched words go into a small prefetch queue, which the control unit drains through a valid/ready handshake. A redirect input flushes the queue and restarts fetch at a new address for branches and PC writes.

## Interface
- DEPTH, 2, prefetch queue entries; power of two, ≥2
- RESET_PC, 32'h0, word address fetched first after reset
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- mem_a  out  32  RAM word address, combinational from fetch_pc
- mem_rw  out  1  RAM write enable; constant 0
- mem_dout  in  32  RAM read data, valid the cycle after its address was sampled
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new word address
- inst_valid  out  1  inst/inst_pc hold a fetched word
- inst_ready  in  1  consumer accepts this cycle
- inst  out  32  instruction word (0 when not valid)
- inst_pc  out  32  word address of inst (0 when not valid)

## Operation
- State: fetch_pc[31:0], inflight (1 bit), inflight_pc[31:0], queue of DEPTH {pc, inst} entries with count.
- pop = inst_valid & inst_ready.
- issue = !redirect & (count + inflight − pop < DEPTH). Widths are $clog2(DEPTH+1) bits, computed without underflow.
- On issue: inflight ← 1, inflight_pc ← fetch_pc, fetch_pc ← fetch_pc + 1. Addresses are in words, and the 32-bit increment wraps 32'hFFFFFFFF → 0.
- When issue is low: inflight ← 0 and fetch_pc holds.
- Arrival: while inflight=1, mem_dout is pushed as {inflight_pc, mem_dout} at the cycle's edge.
- Queue: FIFO order, pointers wrap mod DEPTH. Push and pop in the same cycle leave count unchanged. The issue rule guarantees no push when full.
- Redirect cycle:
  - a pop that cycle still completes;
  - all remaining entries are discarded and count ← 0;
  - inflight ← 0, so the word arriving next cycle is dropped;
  - fetch_pc ← redirect_pc, with no issue that cycle.
- Back-to-back redirects: the last one wins.
- Consumer stall (inst_ready=0): inst/inst_pc hold stable while inst_valid=1. Fetch continues until count + inflight = DEPTH.

## Timing
- Reset values (asynchronous): fetch_pc=RESET_PC, inflight=0, count=0, inst_valid=0, inst=0, inst_pc=0, mem_rw=0.
- Reset asserted mid-stream discards everything, including the in-flight read.
- First fetch: issue in cycle 0 after rst_n rises; data arrives in cycle 1; inst_valid=1 in cycle 2.
- Redirect in cycle N: no issue in N; redirect_pc issues in N+1; inst_valid rises in N+3 (N+2 with bypass).
- Steady state with inst_ready=1: one instruction per cycle, sequential inst_pc.

## Configuration
- IFU_BYPASS_EN defined:
  - when count=0 and a word is arriving, inst_valid=1 combinationally with inst=mem_dout and inst_pc=inflight_pc;
  - if inst_ready is high, the word is not enqueued;
  - fetch-to-valid latency drops from 2 to 1 cycle.
- IFU_BYPASS_EN undefined: all outputs come from queue registers, with no combinational path from mem_dout to inst.

## Structure
- Shared package limb_pkg: WORD_W=32, the word_t typedef, the RESET_PC default, and a fetch_entry_t struct {pc, inst}.
- One sub-module, prefetch_queue: synchronous FIFO of fetch_entry_t with push, pop, flush, count and head outputs. The fetch unit owns PC, inflight tracking and the issue rule.

## Test plan
- Reset release, RAM[0..3]=E3A01005, E3A02007, E3A03009, E3A0400B, inst_ready=1 → inst_valid rises cycle 2 and outputs 0..3 appear on consecutive cycles with inst_pc 0,1,2,3.
- inst_ready=0 for 5 cycles after first valid → count reaches DEPTH, mem_a stops advancing, inst=E3A01005 held. Release → in-order 0,1,2,… with no loss or duplication.
- Redirect to 0x100 while queue full and a read in flight → next valid has inst_pc=0x100 exactly 3 cycles later; no word from the old stream appears.
- Redirect asserted during a pop of inst_pc=5 → word 5 is consumed once; the next valid has inst_pc=redirect_pc.
- rst_n pulsed low mid-stream (fetch_pc=0x20) → outputs immediately 0; after release fetch restarts at RESET_PC.
- With IFU_BYPASS_EN, reset release → inst_valid=1 in cycle 1 with inst=E3A01005; queue count stays 0 under continuous inst_ready=1.
